// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM encoding,
// the instruction-buffer entry layout and fixed constants.
package cpu_pkg;

    // Fetch FSM encoding, kept as plain constants for legacy tools
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] PC_INC = 32'd4;

    // One buffered fetch result: the word and the address it came from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus: request channel with valid/ready and an
// in-order response channel with a valid strobe only.
interface if_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// Small instruction buffer between the fetch FSM and IF/ID.
// Flush wins over a same-cycle push; a push into a full buffer is
// accepted only when a pop frees the slot in the same cycle.
module if_fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_data,
    output fetch_entry_t rd_data,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the buffer
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps at most one request
// outstanding to instruction memory, buffers returned words and hands
// the oldest one to IF/ID. Redirects flush the buffer and drop the
// response of any request that was already committed to the bus.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    if_fetch_unit_if.master       imem,
    input  logic                  id_stall,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  inst_valid,
    output logic [31:0]           inst,
    output logic [31:0]           inst_pc,
    output logic [31:0]           inst_pc_plus4
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]   state, state_next;
    logic [31:0]  pc, pc_next;
    logic [31:0]  req_addr, req_addr_next;
    logic         discard, discard_next;

    logic [CW-1:0] count, count_after;
    logic          empty, full;
    logic          push, pop, handshake, resp;
    fetch_entry_t  head, wr_entry;

    assign handshake = (state == S_REQ) && imem.imem_req_ready;
    assign resp      = (state == S_WAIT) && imem.imem_resp_valid;
    assign pop       = !empty && !id_stall && !redirect_valid;
    assign push      = resp && !discard && !redirect_valid;
    assign wr_entry  = '{inst: imem.imem_resp_data, pc: req_addr};

    // Occupancy once this cycle's push/pop/flush has taken effect
    assign count_after = redirect_valid ? '0
                       : count + CW'(push) - CW'(pop);

    if_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Next-state, PC and discard decisions for the fetch FSM
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        discard_next  = discard;
        if (redirect_valid) pc_next = redirect_pc;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && !full) begin
                    state_next    = S_REQ;
                    req_addr_next = pc;
                end
            end
            S_REQ: begin
                if (redirect_valid) discard_next = 1'b1;
                if (handshake) begin
                    state_next = S_WAIT;
                    if (!redirect_valid && !discard) pc_next = pc + PC_INC;
                end
            end
            S_WAIT: begin
                if (resp) begin
                    discard_next = 1'b0;
                    if (count_after < CW'(DEPTH)) begin
                        state_next    = S_REQ;
                        req_addr_next = redirect_valid ? redirect_pc : pc;
                    end else begin
                        state_next = S_IDLE;
                    end
                end else if (redirect_valid) begin
                    discard_next = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // FSM and PC registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
            discard  <= discard_next;
        end
    end

    assign imem.imem_req_valid = (state == S_REQ);
    assign imem.imem_req_addr  = req_addr;

    assign inst_valid    = !empty;
    assign inst          = empty ? NOP   : head.inst;
    assign inst_pc       = empty ? 32'h0 : head.pc;
    assign inst_pc_plus4 = empty ? 32'h0 : head.pc + PC_INC;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: a variable-latency memory model
// answers with addr ^ KEY, and a scoreboard holds the PC stream expected
// at IF/ID since the last reset or redirect.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;

    if_fetch_unit_if imem_bus ();

    if_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Single comparison point for every check in the bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    // Memory model state: one pending request with a countdown
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_wait = 0;
    int          resp_delay = 0;
    int          resp_redirect_hits = 0;

    // Record handshakes and consumed responses at the clock edge
    always @(posedge clk) begin
        if (!rst_n) begin
            mem_pend = 1'b0;
        end else begin
            if (imem_bus.imem_resp_valid === 1'b1) begin
                mem_pend = 1'b0;
                if (redirect_valid) resp_redirect_hits++;
            end
            if (imem_bus.imem_req_valid && imem_bus.imem_req_ready) begin
                mem_pend = 1'b1;
                mem_addr = imem_bus.imem_req_addr;
                mem_wait = resp_delay;
            end
        end
    end

    // Drive the response channel half a cycle ahead of the next edge
    always @(negedge clk) begin
        if (mem_pend && mem_wait == 0) begin
            imem_bus.imem_resp_valid = 1'b1;
            imem_bus.imem_resp_data  = mem_addr ^ KEY;
        end else begin
            imem_bus.imem_resp_valid = 1'b0;
            imem_bus.imem_resp_data  = 32'h0;
            if (mem_pend && mem_wait > 0) mem_wait--;
        end
    end

    // Expected PC stream since the last reset or redirect
    logic [31:0] exp_q[$];

    task automatic sbRestart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 48; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Compare every instruction IF/ID actually takes this cycle
    always @(negedge clk) begin
        logic [31:0] exp_pc;
        if (rst_n && inst_valid && !id_stall && !redirect_valid) begin
            checkOutput("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_pc = exp_q.pop_front();
                checkOutput("sb_inst_pc", inst_pc, exp_pc);
                checkOutput("sb_inst", inst, exp_pc ^ KEY);
                checkOutput("sb_inst_pc_plus4", inst_pc_plus4, exp_pc + 32'd4);
            end
        end
    end

    // Set this cycle's decode-side inputs, then advance one clock
    task automatic applyStimulus(input logic stall, input logic rv, input logic [31:0] rpc);
        id_stall       = stall;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) sbRestart(rpc);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbRestart(RESET_PC);
    endtask

    task automatic waitInstValid(input string tag);
        for (int i = 0; i < 40 && !inst_valid; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput(tag, 32'(inst_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hits_before;
        id_stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_bus.imem_req_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
        checkOutput("rst_inst_pc_plus4", inst_pc_plus4, 32'h0);
        rst_n = 1'b1;
        sbRestart(RESET_PC);

        $display("[TB] zero-wait streaming and first-valid latency");
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("c1_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("c1_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
        checkOutput("c1_req_addr", imem_bus.imem_req_addr, RESET_PC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("c2_inst_valid", 32'(inst_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("c3_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("c3_inst_pc", inst_pc, 32'h0);

        $display("[TB] request held while ready is low");
        for (int i = 0; i < 20 && !(imem_bus.imem_req_valid && imem_bus.imem_req_addr == 32'h8); i++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("find_req_8", 32'(imem_bus.imem_req_valid && imem_bus.imem_req_addr == 32'h8), 32'd1);
        imem_bus.imem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("hold_req_valid", 32'(imem_bus.imem_req_valid), 32'd1);
            checkOutput("hold_req_addr", imem_bus.imem_req_addr, 32'h8);
        end
        imem_bus.imem_req_ready = 1'b1;
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] decode stall fills the buffer");
        id_stall = 1'b1;
        applyReset();
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            if (i >= 7) checkOutput("stall_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        end
        checkOutput("stall_inst_valid", 32'(inst_valid), 32'd1);
        checkOutput("stall_head_pc", inst_pc, 32'h0);
        checkOutput("stall_head_inst", inst, 32'h0 ^ KEY);

        $display("[TB] redirect while a response is in flight");
        resp_delay = 3;
        for (int i = 0; i < 40 && !(mem_pend && mem_addr == 32'hC); i++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("find_hs_C", 32'(mem_pend && mem_addr == 32'hC), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'h100);
        checkOutput("redir_flush", 32'(inst_valid), 32'd0);
        waitInstValid("redir_100_valid");
        checkOutput("redir_100_pc", inst_pc, 32'h100);

        $display("[TB] back-to-back redirects with discard pending");
        for (int i = 0; i < 40 && !(mem_pend && mem_wait == resp_delay); i++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("find_fresh_hs", 32'(mem_pend && mem_wait == resp_delay), 32'd1);
        hits_before = resp_redirect_hits;
        applyStimulus(1'b0, 1'b1, 32'h180);
        applyStimulus(1'b0, 1'b1, 32'h1C0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h200);
        checkOutput("resp_with_redirect", 32'(resp_redirect_hits - hits_before), 32'd1);
        checkOutput("redir2_flush", 32'(inst_valid), 32'd0);
        waitInstValid("redir_200_valid");
        checkOutput("redir_200_pc", inst_pc, 32'h200);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] reset in the middle of a wait");
        id_stall = 1'b1;
        applyReset();
        for (int i = 0; i < 30 && !(mem_pend && mem_addr == 32'h4); i++)
            applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("mid_wait_count1", 32'(inst_valid), 32'd1);
        checkOutput("mid_wait_head", inst_pc, 32'h0);
        resp_delay = 0;
        applyReset();
        checkOutput("mrst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("mrst_req_valid", 32'(imem_bus.imem_req_valid), 32'd0);
        checkOutput("mrst_req_addr", imem_bus.imem_req_addr, RESET_PC);
        waitInstValid("mrst_first_valid");
        checkOutput("mrst_first_pc", inst_pc, RESET_PC);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("[TB] PC wrap at the top of the address space");
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
        waitInstValid("wrap_valid");
        checkOutput("wrap_pc", inst_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_plus4", inst_pc_plus4, 32'h0);
        repeat (12) applyStimulus(1'b0, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch front end for the 5-stage pipelined CPU, directly upstream of the IF/ID pipeline register. It owns the PC and issues one-outstanding requests to an instruction memory that has a valid/ready handshake and variable latency. Returned words go into a small FIFO, and the FIFO head is presented to IF/ID with a valid bit. It honours a stall (hold) from decode and a PC redirect (branch/jump) from later stages.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 2, instruction-buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  fetch byte address
imem_resp_valid  input  1  read data valid (one per accepted request, in order)
imem_resp_data  input  32  instruction word
id_stall  input  1  IF/ID holding; do not pop
redirect_valid  input  1  load new PC and flush
redirect_pc  input  32  target PC
inst_valid  output  1  inst/inst_pc valid for IF/ID
inst  output  32  instruction; 32'h0 (nop) when inst_valid=0
inst_pc  output  32  address of inst
inst_pc_plus4  output  32  inst_pc + 4, mod 2^32

Behaviour:
- Reset (rst_n=0 at edge) sets: pc=RESET_PC, FIFO empty, state=IDLE, discard=0. Registered outputs read as imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_pc_plus4=0. Reset overrides everything, including a request in flight. Responses arriving after reset for pre-reset requests are the memory's problem; the memory is reset together with this block.
- FSM states:
  - IDLE:
    - if free>0 and no redirect -> REQ (latch req_addr=pc).
    - free = DEPTH - count - (outstanding ? 1 : 0).
  - REQ:
    - imem_req_valid=1, imem_req_addr=req_addr.
    - Must stay asserted with a stable address until imem_req_ready (no withdrawal, even on redirect).
    - On handshake: pc<=pc+4 (unless redirect), -> WAIT.
  - WAIT:
    - On imem_resp_valid: push {resp_data, req_addr} unless discard.
    - Next state: REQ if free space remains after the push (latch new req_addr=pc), else IDLE.
- Max one request outstanding. Throughput is 1 instruction per 2 cycles with a zero-wait memory.
- Output:
  - FIFO head drives inst/inst_pc/inst_pc_plus4, with inst_valid = !empty.
  - Pop when inst_valid && !id_stall.
  - Push and pop in the same cycle are legal on a full FIFO only if the pop frees the slot first; the count is unchanged.
- Redirect (highest priority after reset):
  - pc<=redirect_pc, FIFO flushed (count=0), and no pop is counted that cycle.
  - If a request is accepted or pending (state REQ or WAIT), set discard=1.
  - The next response with discard=1 is dropped and clears discard. A response in the same cycle as the redirect is also dropped.
  - In REQ, the old request completes its handshake, then the FSM goes to WAIT with discard set.
  - pc is not incremented on the handshake when a redirect is pending.
- A second redirect while discard=1 only updates pc; discard stays 1 (still one outstanding).
- PC arithmetic is 32-bit wrap: 32'hFFFF_FFFC + 4 = 32'h0.
- Low 2 bits of redirect_pc are passed through unchanged (no alignment check).

Decomposition:
- Shared package cpu_pkg:
  - fetch state enum (IDLE/REQ/WAIT)
  - NOP constant 32'h0
  - PC_INC constant 32'd4
- One sub-module: if_fetch_fifo. It is a synchronous DEPTH-entry FIFO of {inst[31:0], pc[31:0]} with push, pop, flush, full, empty and count. On a simultaneous flush and push, flush wins.

Test Plan:
- Reset, then a zero-wait memory returning word = addr ^ 32'hA5A5_0000:
  - required: inst_valid first high in cycle 3 after release, with inst_pc 0, 4, 8… in order.
  - required: inst matches for every pc, and inst_pc_plus4 = inst_pc + 4.
- imem_req_ready held low 5 cycles with imem_req_valid=1:
  - required: imem_req_addr stable at 32'h8 throughout, and no pc advance until the handshake.
- id_stall=1 for 10 cycles:
  - required: the FIFO fills to DEPTH=2 and imem_req_valid then stays 0.
  - required: inst/inst_pc frozen at the head (pc 0).
  - required: after release, pc 0, 4, 8 come out with no loss or duplication.
- redirect_valid with redirect_pc=32'h100 while in WAIT:
  - required: the in-flight response (addr 32'hC) is dropped and the FIFO is flushed.
  - required: the next inst_valid shows inst_pc=32'h100.
- Redirect in the same cycle as imem_resp_valid, and a second redirect to 32'h200 while discard=1:
  - required: both old words are dropped and the first delivered inst_pc=32'h200.
- rst_n low for one cycle mid-WAIT with FIFO count=1:
  - required: the next cycle shows inst_valid=0, imem_req_valid=0, pc=RESET_PC.
- Boundary: redirect_pc=32'hFFFF_FFFC:
  - required: inst_pc sequence FFFF_FFFC, 0000_0000, with inst_pc_plus4 of the first = 32'h0.
